// File: rtl/weight_pack_loader.sv
// Boot-time weight loader: streams byte-wide weight segments from a source
// memory, packs PACK elements per word and writes them to the PE weight BRAM.
module weight_pack_loader #(
  parameter int ELEM_W = 8,
  parameter int PACK = 9,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 12,
  parameter int RD_LAT = 1,
  parameter int SRC_BASE = 0,
  parameter int NUM_SEG = 3,
  parameter logic [16*NUM_SEG-1:0] SEG_LEN = {16'd23040, 16'd1152, 16'd72},
  parameter logic [16*NUM_SEG-1:0] SEG_DST_BASE = {16'd160, 16'd32, 16'd0},
  parameter logic [NUM_SEG-1:0] SEG_MODE = 3'b100,
  parameter int TILE = 8,
  parameter int ILV_A = 2,
  parameter int ILV_B = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     force_reload,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     loaded,
  output logic [1:0]               seg_id,
  output logic                     src_en,
  output logic [SRC_AW-1:0]        src_addr,
  input  logic [ELEM_W-1:0]        src_dout,
  output logic                     dst_en,
  output logic                     dst_we,
  output logic [DST_AW-1:0]        dst_addr,
  output logic [ELEM_W*PACK-1:0]   dst_din
);

  localparam int DST_W = ELEM_W * PACK;
  localparam int SLW = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, SKIP} state_t;

  state_t             state;
  logic [1:0]         rseg;
  logic [15:0]        rcnt;
  logic [1:0]         wseg;
  logic [15:0]        wword;
  logic [SLW-1:0]     wslot;
  logic [DST_W-1:0]   pbuf;
  logic [RD_LAT-1:0]  pv;
  logic [RD_LAT-1:0]  psl;
  logic [RD_LAT-1:0]  pal;
  logic               dst_last;

  logic [15:0]        rd_len;
  logic               rd_seg_last;
  logic               rd_all_last;
  logic               arr;
  logic               a_sl;
  logic               a_al;
  logic               wr_full;
  logic               restart;
  logic [DST_W-1:0]   wr_word;
  logic [15:0]        wr_addr;

  // Tile-interleaved or linear destination address, 16b arithmetic.
  function automatic logic [15:0] map_addr(
    input logic [15:0] base,
    input logic        mode,
    input logic [15:0] w
  );
    logic [15:0] t;
    logic [15:0] grp;
    logic [15:0] g;
    logic [15:0] slot;
    t = w / 16'(TILE);
    grp = t / 16'(ILV_A * ILV_B);
    g = t % 16'(ILV_A * ILV_B);
    slot = (g % 16'(ILV_A)) * 16'(ILV_B) + g / 16'(ILV_A);
    if (mode)
      map_addr = base + w % 16'(TILE) + 16'(TILE) * slot
               + 16'(TILE * ILV_A * ILV_B) * grp;
    else
      map_addr = base + w;
  endfunction

  assign rd_len = SEG_LEN[16*rseg +: 16];
  assign rd_seg_last = (rcnt == rd_len - 16'd1);
  assign rd_all_last = rd_seg_last && (rseg == 2'(NUM_SEG - 1));

  assign arr = pv[RD_LAT-1];
  assign a_sl = psl[RD_LAT-1];
  assign a_al = pal[RD_LAT-1];
  assign wr_full = (wslot == SLW'(PACK - 1)) || a_sl;
  assign wr_word = pbuf | (DST_W'(src_dout) << (ELEM_W * int'(wslot)));
  assign wr_addr = map_addr(SEG_DST_BASE[16*wseg +: 16], SEG_MODE[wseg], wword);
  assign restart = (state == IDLE) && start;
  assign dst_en = dst_we;

  // Control FSM and read-side issue counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      loaded <= 1'b0;
      seg_id <= 2'd0;
      src_en <= 1'b0;
      src_addr <= '0;
      rseg <= 2'd0;
      rcnt <= 16'd0;
    end else if (abort) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      loaded <= 1'b0;
      src_en <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (!loaded || force_reload) begin
              state <= RUN;
              busy <= 1'b1;
              loaded <= 1'b0;
              src_en <= 1'b1;
              src_addr <= SRC_AW'(SRC_BASE);
              rseg <= 2'd0;
              rcnt <= 16'd0;
              seg_id <= 2'd0;
            end else begin
              state <= SKIP;
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_all_last) begin
            state <= DRAIN;
            src_en <= 1'b0;
          end else begin
            src_addr <= src_addr + SRC_AW'(1);
            if (rd_seg_last) begin
              rseg <= rseg + 2'd1;
              seg_id <= rseg + 2'd1;
              rcnt <= 16'd0;
            end else begin
              rcnt <= rcnt + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (dst_we && dst_last) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            loaded <= 1'b1;
          end
        end
        SKIP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag pipeline matching the source read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      psl <= '0;
      pal <= '0;
    end else if (abort) begin
      pv <= '0;
    end else begin
      pv[0] <= src_en;
      psl[0] <= rd_seg_last;
      pal[0] <= rd_all_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        psl[i] <= psl[i-1];
        pal[i] <= pal[i-1];
      end
    end
  end

  // Pack arriving elements and emit registered destination writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_we <= 1'b0;
      dst_addr <= '0;
      dst_din <= '0;
      dst_last <= 1'b0;
      pbuf <= '0;
      wslot <= '0;
      wseg <= 2'd0;
      wword <= 16'd0;
    end else begin
      dst_we <= 1'b0;
      dst_last <= 1'b0;
      if (abort || restart) begin
        pbuf <= '0;
        wslot <= '0;
        wseg <= 2'd0;
        wword <= 16'd0;
      end else if (arr) begin
        if (wr_full) begin
          dst_we <= 1'b1;
          dst_addr <= DST_AW'(wr_addr);
          dst_din <= wr_word;
          dst_last <= a_al;
          pbuf <= '0;
          wslot <= '0;
          if (a_sl) begin
            wseg <= wseg + 2'd1;
            wword <= 16'd0;
          end else begin
            wword <= wword + 16'd1;
          end
        end else begin
          pbuf <= wr_word;
          wslot <= wslot + SLW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_pack_loader.sv
// Bench for weight_pack_loader: default instance plus a small RD_LAT=2
// instance, checked against a word-level reference model of the load.
module tb_weight_pack_loader;

  logic clk = 1'b0;
  logic reset;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Cycle counter used to stamp observed events.
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:32767];

  logic a_start, a_force, a_abort;
  logic a_busy, a_done, a_loaded;
  logic [1:0] a_seg;
  logic a_src_en;
  logic [14:0] a_src_addr;
  logic [7:0] a_dout;
  logic a_dst_en, a_dst_we;
  logic [11:0] a_dst_addr;
  logic [71:0] a_dst_din;

  logic b_start, b_force, b_abort;
  logic b_busy, b_done, b_loaded;
  logic [1:0] b_seg;
  logic b_src_en;
  logic [14:0] b_src_addr;
  logic [7:0] b_dout, b_q1;
  logic b_dst_en, b_dst_we;
  logic [11:0] b_dst_addr;
  logic [71:0] b_dst_din;

  weight_pack_loader u_a (
    .clk(clk), .reset(reset), .start(a_start),
    .force_reload(a_force), .abort(a_abort),
    .busy(a_busy), .done(a_done), .loaded(a_loaded),
    .seg_id(a_seg), .src_en(a_src_en), .src_addr(a_src_addr),
    .src_dout(a_dout), .dst_en(a_dst_en), .dst_we(a_dst_we),
    .dst_addr(a_dst_addr), .dst_din(a_dst_din)
  );

  weight_pack_loader #(
    .RD_LAT(2), .SRC_BASE(5), .NUM_SEG(2),
    .SEG_LEN({16'd20, 16'd10}),
    .SEG_DST_BASE({16'd100, 16'd4}),
    .SEG_MODE(2'b10),
    .TILE(2), .ILV_A(2), .ILV_B(2)
  ) u_b (
    .clk(clk), .reset(reset), .start(b_start),
    .force_reload(b_force), .abort(b_abort),
    .busy(b_busy), .done(b_done), .loaded(b_loaded),
    .seg_id(b_seg), .src_en(b_src_en), .src_addr(b_src_addr),
    .src_dout(b_dout), .dst_en(b_dst_en), .dst_we(b_dst_we),
    .dst_addr(b_dst_addr), .dst_din(b_dst_din)
  );

  // Source memories: latency 1 for A, latency 2 for B.
  always @(posedge clk) begin
    if (a_src_en) a_dout <= mem[a_src_addr];
    if (b_src_en) b_q1 <= mem[b_src_addr];
    b_dout <= b_q1;
  end

  logic [11:0] g_addr [0:8191];
  logic [71:0] g_data [0:8191];
  int a_wr_n = 0, a_wr_t = 0, a_done_n = 0, a_done_t = 0;
  int a_src_n = 0, a_src_t = 0, a_gap = 0, a_en_bad = 0;
  logic a_pen = 1'b0;
  logic [14:0] a_paddr = '0;

  // Monitor of instance A.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_src_en) begin
        if (a_pen && a_src_addr !== a_paddr + 15'd1) a_gap++;
        a_src_n++;
        a_src_t = cyc;
      end
      a_pen = a_src_en;
      a_paddr = a_src_addr;
      if (a_dst_en !== a_dst_we) a_en_bad++;
      if (a_dst_we) begin
        g_addr[a_wr_n % 8192] = a_dst_addr;
        g_data[a_wr_n % 8192] = a_dst_din;
        a_wr_n++;
        a_wr_t = cyc;
      end
      if (a_done) begin
        a_done_n++;
        a_done_t = cyc;
      end
    end
  end

  logic [11:0] h_addr [0:63];
  logic [71:0] h_data [0:63];
  int b_wr_n = 0, b_wr_t = 0, b_done_n = 0, b_done_t = 0, b_src_n = 0;

  // Monitor of instance B.
  always @(negedge clk) begin
    if (!reset) begin
      if (b_src_en) b_src_n++;
      if (b_dst_we) begin
        h_addr[b_wr_n % 64] = b_dst_addr;
        h_data[b_wr_n % 64] = b_dst_din;
        b_wr_n++;
        b_wr_t = cyc;
      end
      if (b_done) begin
        b_done_n++;
        b_done_t = cyc;
      end
    end
  end

  logic [11:0] exp_addr [0:4095];
  logic [71:0] exp_data [0:4095];
  int exp_n;
  int s0, bw, bd, bs, bg;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Word-level model: every segment is cut into PACK-element words.
  task automatic build_exp(input int sbase, input int nseg, input int lens[4],
                           input int bases[4], input int modes[4],
                           input int tile, input int ia, input int ib);
    int off;
    int nw;
    int t, grp, g, addr;
    logic [71:0] d;
    off = 0;
    exp_n = 0;
    for (int s = 0; s < nseg; s++) begin
      nw = (lens[s] + 8) / 9;
      for (int w = 0; w < nw; w++) begin
        d = '0;
        for (int j = 0; j < 9; j++)
          if (w * 9 + j < lens[s]) d[8*j +: 8] = mem[sbase + off + w * 9 + j];
        if (modes[s] == 0) begin
          addr = bases[s] + w;
        end else begin
          t = w / tile;
          grp = t / (ia * ib);
          g = t % (ia * ib);
          addr = bases[s] + w % tile + tile * ((g % ia) * ib + g / ia)
               + tile * ia * ib * grp;
        end
        exp_addr[exp_n] = 12'(addr);
        exp_data[exp_n] = d;
        exp_n++;
      end
      off += lens[s];
    end
  endtask

  task automatic cmp_a(input string tag, input int base, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (g_addr[(base + i) % 8192] !== exp_addr[i] ||
          g_data[(base + i) % 8192] !== exp_data[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic begin_a(input logic frc);
    bw = a_wr_n;
    bd = a_done_n;
    bs = a_src_n;
    bg = a_gap;
    a_force = frc;
    a_start = 1'b1;
    s0 = cyc;
    step(1);
    a_start = 1'b0;
    a_force = 1'b0;
  endtask

  task automatic wait_a(input string tag, input int lim);
    int k;
    k = 0;
    while (a_done_n == bd && k < lim) begin
      step(1);
      k++;
    end
    chk(tag, a_done_n != bd, 1);
    step(3);
  endtask

  // Full default load: N = 24264, RD_LAT = 1.
  task automatic check_full(input string tag);
    chk({tag, "_done_cnt"}, a_done_n - bd, 1);
    chk({tag, "_done_cyc"}, a_done_t - s0, 24267);
    chk({tag, "_src_cnt"}, a_src_n - bs, 24264);
    chk({tag, "_src_last"}, a_src_t - s0, 24264);
    chk({tag, "_src_gap"}, a_gap - bg, 0);
    chk({tag, "_wr_cnt"}, a_wr_n - bw, 2696);
    chk({tag, "_wr_last"}, a_wr_t - s0, 24266);
    cmp_a({tag, "_words"}, bw, exp_n);
    chk({tag, "_loaded"}, {a_loaded, a_busy}, 2'b10);
  endtask

  int ws[6] = '{0, 8, 16, 24, 64, 2559};
  int as[6] = '{160, 192, 168, 200, 224, 2719};
  logic [71:0] w1;
  int bb;

  initial begin
    reset = 1'b1;
    {a_start, a_force, a_abort} = '0;
    {b_start, b_force, b_abort} = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 8'(i);
    step(2);
    chk("a_reset_outs", {a_busy, a_done, a_loaded, a_seg, a_src_en,
        a_src_addr, a_dst_en, a_dst_we, a_dst_addr, a_dst_din}, 0);
    chk("b_reset_outs", {b_busy, b_done, b_loaded, b_seg, b_src_en,
        b_src_addr, b_dst_en, b_dst_we, b_dst_addr, b_dst_din}, 0);
    reset = 1'b0;
    step(2);

    build_exp(0, 3, '{72, 1152, 23040, 0}, '{0, 32, 160, 0},
              '{0, 0, 1, 0}, 8, 2, 4);
    begin_a(1'b0);
    wait_a("r1_done_seen", 30000);
    check_full("r1");
    chk("r1_first_addr", g_addr[bw % 8192], 0);
    chk("r1_first_word", g_data[bw % 8192], 72'h080706050403020100);
    chk("r1_seg1_first", g_addr[(bw + 8) % 8192], 32);
    chk("r1_seg1_last", g_addr[(bw + 135) % 8192], 159);
    for (int i = 0; i < 6; i++)
      chk($sformatf("r1_ilv_w%0d", ws[i]),
          g_addr[(bw + 136 + ws[i]) % 8192], as[i]);
    chk("r1_en_eq_we", a_en_bad, 0);

    begin_a(1'b0);
    chk("skip_done_next", a_done, 1'b1);
    chk("skip_busy", a_busy, 1'b0);
    step(10);
    chk("skip_done_cnt", a_done_n - bd, 1);
    chk("skip_done_cyc", a_done_t - s0, 1);
    chk("skip_no_access", {a_src_n - bs, a_wr_n - bw}, 0);
    chk("skip_loaded", a_loaded, 1'b1);

    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    build_exp(0, 3, '{72, 1152, 23040, 0}, '{0, 32, 160, 0},
              '{0, 0, 1, 0}, 8, 2, 4);
    begin_a(1'b1);
    step(99);
    a_start = 1'b1;
    a_force = 1'b1;
    step(1);
    a_start = 1'b0;
    a_force = 1'b0;
    wait_a("r2_done_seen", 30000);
    check_full("r2");

    begin_a(1'b1);
    step(499);
    a_abort = 1'b1;
    step(1);
    a_abort = 1'b0;
    chk("abort_idle", {a_busy, a_src_en, a_dst_we, a_loaded, a_done}, 0);
    step(40);
    chk("abort_wr_cnt", a_wr_n - bw, 55);
    chk("abort_wr_last", a_wr_t - s0, 497);
    cmp_a("abort_prefix", bw, a_wr_n - bw);
    chk("abort_no_done", a_done_n - bd, 0);
    chk("abort_loaded", a_loaded, 1'b0);

    begin_a(1'b0);
    step(299);
    chk("rst_mid_busy", a_busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", {a_busy, a_done, a_loaded, a_seg, a_src_en,
        a_src_addr, a_dst_en, a_dst_we, a_dst_addr, a_dst_din}, 0);
    step(2);
    reset = 1'b0;
    step(3);
    chk("rst_after", {a_busy, a_src_en, a_loaded}, 0);

    build_exp(5, 2, '{10, 20, 0, 0}, '{4, 100, 0, 0},
              '{0, 1, 0, 0}, 2, 2, 2);
    bb = b_wr_n;
    bd = b_done_n;
    bs = b_src_n;
    b_start = 1'b1;
    s0 = cyc;
    step(1);
    b_start = 1'b0;
    for (int k = 0; k < 200 && b_done_n == bd; k++) step(1);
    chk("b_done_seen", b_done_n != bd, 1);
    step(3);
    chk("b_done_cyc", b_done_t - s0, 34);
    chk("b_src_cnt", b_src_n - bs, 30);
    chk("b_wr_cnt", b_wr_n - bb, exp_n);
    chk("b_wr_last", b_wr_t - s0, 33);
    for (int i = 0; i < 5; i++)
      chk($sformatf("b_word%0d", i),
          {h_addr[(bb + i) % 64], h_data[(bb + i) % 64]},
          {exp_addr[i], exp_data[i]});
    w1 = {64'h0, mem[14]};
    chk("b_pad_word", h_data[(bb + 1) % 64], w1);
    chk("b_seg1_slot0", h_data[(bb + 2) % 64][7:0], mem[15]);
    chk("b_ilv_addr", h_addr[(bb + 4) % 64], 104);
    chk("b_loaded", b_loaded, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
